// File: rtl/mult_scheduler.sv
// rtl/mult_scheduler.sv - round-robin scheduler sharing one multiplier between two requesters
// Defining MULT_SCHED_TIMEOUT_EN bounds S_wait to TIMEOUT cycles and adds timeout_err.
module mult_scheduler #(
  parameter int L_word  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [L_word-1:0]     word1_0,
  input  logic [L_word-1:0]     word2_0,
  input  logic [L_word-1:0]     word1_1,
  input  logic [L_word-1:0]     word2_1,
  output logic                  done0,
  output logic                  done1,
  output logic [2*L_word-1:0]   product0,
  output logic [2*L_word-1:0]   product1,
  output logic                  busy,
  output logic [L_word-1:0]     mult_word1,
  output logic [L_word-1:0]     mult_word2,
  output logic                  mult_start,
`ifdef MULT_SCHED_TIMEOUT_EN
  output logic                  timeout_err,
`endif
  input  logic                  mult_ready,
  input  logic [2*L_word-1:0]   mult_product
);

  typedef enum logic [1:0] {S_idle, S_issue, S_wait, S_resp} state_t;

  state_t              state, state_nxt;
  logic                owner;
  logic                prio1;
  logic                pick;
  logic                grant;
  logic                capture;
  logic [2*L_word-1:0] cap_val;

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          timed_out;
`endif

  always_comb begin
    state_nxt = state;
    pick      = (req0 && req1) ? prio1 : req1;
    cap_val   = mult_product;
    case (state)
      S_idle:  if ((req0 || req1) && mult_ready) state_nxt = S_issue;
      S_issue: state_nxt = S_wait;
      S_wait: begin
        if (mult_ready) begin
          state_nxt = S_resp;
        end
`ifdef MULT_SCHED_TIMEOUT_EN
        else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          state_nxt = S_resp;
          cap_val   = '0;
        end
`endif
      end
      S_resp:  state_nxt = S_idle;
      default: state_nxt = S_idle;
    endcase
  end

  assign grant      = (state == S_idle) && (state_nxt == S_issue);
  assign capture    = (state == S_wait) && (state_nxt == S_resp);
  assign busy       = (state != S_idle);
  assign mult_start = (state == S_issue);
  assign done0      = (state == S_resp) && !owner;
  assign done1      = (state == S_resp) && owner;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_idle;
      owner      <= 1'b0;
      prio1      <= 1'b0;
      mult_word1 <= '0;
      mult_word2 <= '0;
      product0   <= '0;
      product1   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner      <= pick;
        prio1      <= ~pick;
        mult_word1 <= pick ? word1_1 : word1_0;
        mult_word2 <= pick ? word2_1 : word2_0;
      end
      // Only the owner's product is touched; the other keeps its last result.
      if (capture) begin
        if (owner) product1 <= cap_val;
        else       product0 <= cap_val;
      end
    end
  end

`ifdef MULT_SCHED_TIMEOUT_EN
  assign timeout_err = (state == S_resp) && timed_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state == S_issue) begin
        wait_cnt  <= '0;
        timed_out <= 1'b0;
      end else if (state == S_wait) begin
        wait_cnt <= wait_cnt + CW'(1);
        if (capture && !mult_ready) timed_out <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mult_scheduler.sv
// tb/tb_mult_scheduler.sv - directed self-checking bench for mult_scheduler
// Contains a simple variable-latency multiplier model driving mult_ready/mult_product.
module tb_mult_scheduler;
  localparam int L = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           req0 = 1'b0, req1 = 1'b0;
  logic [L-1:0]   word1_0 = '0, word2_0 = '0, word1_1 = '0, word2_1 = '0;
  logic           done0, done1, busy, mult_start, mult_ready;
  logic [2*L-1:0] product0, product1, mult_product;
  logic [L-1:0]   mult_word1, mult_word2;
`ifdef MULT_SCHED_TIMEOUT_EN
  logic           timeout_err;
`endif

  int nchecks = 0, nerr = 0;
  int start_cnt = 0, d0_cnt = 0, d1_cnt = 0;
  int lat = 2, mcnt;
  logic [2*L-1:0] ma, mb;

  mult_scheduler #(.L_word(L), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1),
    .word1_0(word1_0), .word2_0(word2_0), .word1_1(word1_1), .word2_1(word2_1),
    .done0(done0), .done1(done1), .product0(product0), .product1(product1),
    .busy(busy), .mult_word1(mult_word1), .mult_word2(mult_word2),
    .mult_start(mult_start),
`ifdef MULT_SCHED_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .mult_ready(mult_ready), .mult_product(mult_product)
  );

  always #5 clock = ~clock;

  // Multiplier model: lat=0 keeps ready high and updates the product at start.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mult_ready   <= 1'b1;
      mult_product <= '0;
      mcnt         <= 0;
    end else if (mult_start) begin
      ma <= 8'(mult_word1);
      mb <= 8'(mult_word2);
      if (lat == 0) begin
        mult_product <= 8'(mult_word1) * 8'(mult_word2);
      end else begin
        mult_ready <= 1'b0;
        mcnt       <= lat;
      end
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mult_ready   <= 1'b1;
        mult_product <= ma * mb;
      end
    end
  end

  always @(negedge clock) begin
    if (mult_start) start_cnt++;
    if (done0) d0_cnt++;
    if (done1) d1_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp)
      else begin
        nerr++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic wait_done(input bit who, input int limit, output int cyc);
    cyc = 0;
    while (!(who ? done1 : done0) && cyc < limit) begin
      step();
      cyc++;
    end
    check("wait_done_bound", 32'(cyc < limit), 1);
  endtask

  int cyc, snap_s, snap_d;

  initial begin
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done0", done0, 0);
    check("rst_done1", done1, 0);
    check("rst_start", mult_start, 0);
    check("rst_product0", product0, 0);
    check("rst_product1", product1, 0);
    check("rst_word1", mult_word1, 0);
    check("rst_word2", mult_word2, 0);
    reset = 1'b0;
    step();

    // Single request 3x5; operand change mid-operation must not matter
    word1_0 = 3; word2_0 = 5; req0 = 1'b1;
    step();
    check("t1_start", mult_start, 1);
    check("t1_busy", busy, 1);
    check("t1_word1", mult_word1, 3);
    check("t1_word2", mult_word2, 5);
    word1_0 = 7;
    wait_done(0, 20, cyc);
    check("t1_latency", cyc, 4);
    check("t1_product0", product0, 15);
    check("t1_product1", product1, 0);
    req0 = 1'b0;
    step();
    check("t1_done_pulse", done0, 0);
    check("t1_idle", busy, 0);
    check("t1_start_cnt", start_cnt, 1);
    check("t1_done_cnt", d0_cnt, 1);

    // Simultaneous requests from reset: requester 0 first
    reset = 1'b1; step(); reset = 1'b0;
    lat = 1;
    word1_0 = 2; word2_0 = 7; word1_1 = 15; word2_1 = 15;
    req0 = 1'b1; req1 = 1'b1;
    snap_s = start_cnt;
    step();
    check("t2_first_grant", mult_word1, 2);
    wait_done(0, 20, cyc);
    check("t2_product0", product0, 14);
    check("t2_no_overlap", start_cnt - snap_s, 1);
    req0 = 1'b0;
    wait_done(1, 20, cyc);
    check("t2_product1", product1, 225);
    check("t2_product0_hold", product0, 14);
    check("t2_start_cnt", start_cnt - snap_s, 2);
    req1 = 1'b0;
    step();

    // Requester 0 re-requests immediately while 1 waits: grants 0,1,0
    reset = 1'b1; step(); reset = 1'b0;
    word1_0 = 1; word2_0 = 1; word1_1 = 3; word2_1 = 3;
    req0 = 1'b1; req1 = 1'b1;
    wait_done(0, 20, cyc);
    check("t3_product0_a", product0, 1);
    word1_0 = 2; word2_0 = 2;
    cyc = 0;
    step();
    while (!(done0 || done1) && cyc < 20) begin step(); cyc++; end
    check("t3_alt_to_1", done1, 1);
    check("t3_product1", product1, 9);
    req1 = 1'b0;
    wait_done(0, 20, cyc);
    check("t3_product0_b", product0, 4);
    req0 = 1'b0;
    step();

`ifdef MULT_SCHED_TIMEOUT_EN
    // Stalled multiplier: timeout after 64 S_wait cycles
    lat = 1000;
    word1_1 = 5; word2_1 = 5; req1 = 1'b1;
    wait_done(1, 100, cyc);
    check("t6_timeout_cycles", cyc, 66);
    check("t6_timeout_err", timeout_err, 1);
    check("t6_product1", product1, 0);
    req1 = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    word1_1 = 3; word2_1 = 3; req1 = 1'b1; lat = 1;
    wait_done(1, 20, cyc);
    check("t6_restore_product1", product1, 9);
    check("t6_no_timeout_err", timeout_err, 0);
    req1 = 1'b0;
    step();
`endif

    // Zero operands with ready never dropping
    lat = 0;
    word1_1 = 0; word2_1 = 9; req1 = 1'b1;
    wait_done(1, 20, cyc);
    check("t4_latency", cyc, 3);
    check("t4_product1", product1, 0);
    req1 = 1'b0;
    step();
    check("t4_idle", busy, 0);

    // Reset in S_wait aborts without a done pulse
    lat = 30;
    word1_0 = 3; word2_0 = 4; req0 = 1'b1;
    step(); step();
    check("t5_busy_wait", busy, 1);
    snap_d = d0_cnt;
    reset = 1'b1;
    #1;
    check("t5_busy_async", busy, 0);
    check("t5_product0_clr", product0, 0);
    step();
    reset = 1'b0;
    lat = 1;
    wait_done(0, 20, cyc);
    check("t5_product0", product0, 12);
    req0 = 1'b0;
    step();
    check("t5_single_done", d0_cnt - snap_d, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end
endmodule
